// File: rtl/cmp_serial_nbit_if.sv
// Request/result bundle for the bit-serial magnitude comparator.
interface cmp_serial_nbit_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             signed_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/cmp_serial_nbit.sv
// Bit-serial MSB-first magnitude comparator with signed/unsigned modes and
// optional termination at the first differing bit.
module cmp_serial_nbit #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  cmp_serial_nbit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               signed_q, signed_d;
  logic               decided_q, decided_d;
  logic               gt_acc_q, gt_acc_d;
  logic               lt_acc_q, lt_acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               lt_q, lt_d;

  logic a_bit, b_bit, sign_bit, a_wins, b_wins, first_diff;

  // State and datapath registers; rst clears everything and aborts a compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      signed_q  <= 1'b0;
      decided_q <= 1'b0;
      gt_acc_q  <= 1'b0;
      lt_acc_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      signed_q  <= signed_d;
      decided_q <= decided_d;
      gt_acc_q  <= gt_acc_d;
      lt_acc_q  <= lt_acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  // Next-state: latch on start, then examine one MSB per clock until decided
  // (early exit) or the last bit has been examined.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    signed_d  = signed_q;
    decided_d = decided_q;
    gt_acc_d  = gt_acc_q;
    lt_acc_d  = lt_acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    a_bit      = a_sh_q[WIDTH-1];
    b_bit      = b_sh_q[WIDTH-1];
    // The first bit examined is the sign bit; in signed mode a set sign means smaller.
    sign_bit   = signed_q && (cnt_q == CNT_W'(WIDTH - 1));
    a_wins     = sign_bit ? (~a_bit & b_bit) : (a_bit & ~b_bit);
    b_wins     = sign_bit ? (a_bit & ~b_bit) : (~a_bit & b_bit);
    first_diff = ~decided_q & (a_bit ^ b_bit);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d    = bus.a;
          b_sh_d    = bus.b;
          signed_d  = bus.signed_mode;
          cnt_d     = CNT_W'(WIDTH - 1);
          decided_d = 1'b0;
          gt_acc_d  = 1'b0;
          lt_acc_d  = 1'b0;
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        if (first_diff) begin
          decided_d = 1'b1;
          gt_acc_d  = a_wins;
          lt_acc_d  = b_wins;
        end
        if ((cnt_q == '0) || (EARLY_EXIT && first_diff)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          gt_d    = gt_acc_d;
          lt_d    = lt_acc_d;
          eq_d    = ~decided_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = gt_q;
  assign bus.eq   = eq_q;
  assign bus.lt   = lt_q;

endmodule
